rv_skid_fifo: RTL and testbench

RV_SKID_FIFO -- requirements
Module: rv_skid_fifo

---
 rtl/rv_pkg.sv | 12 +
 rtl/rv_fifo_mem.sv | 30 +++
 rtl/rv_skid_fifo.sv | 115 +++++++++++
 tb/tb_rv_skid_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants and helpers for the ready/valid skid FIFO.
package rv_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 4;

   // Occupancy counter width: must hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module rv_fifo_mem
   import rv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write the addressed entry on each enabled rising edge.
   // NOTE: storage is deliberately left out of reset; the control logic guarantees
   // no entry is read before it is written, and state updates use non-blocking <=.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rv_skid_fifo.sv
// Ready/valid FIFO with registered in_ready, no input-to-output bypass, synchronous
// flush and a sticky monitor for upstream payload changes while stalled.
module rv_skid_fifo
   import rv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic [CNT_W-1:0]  count_o,
   output logic              overflow_o
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_nxt;
   logic              ready_q;
   logic              push;
   logic              pop;
   logic              stall;
   logic              stall_q;
   logic [DATA_W-1:0] prev_data_q;
   logic              overflow_q;

   // Handshakes use only registered ready/occupancy, so out_ready_i never reaches in_ready_o.
   assign push        = in_valid_i & ready_q;
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o & out_ready_i;
   assign stall       = in_valid_i & ~ready_q;

   // Next occupancy: flush wins, otherwise increment on push and decrement on pop.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_nxt = count_q;
      if (flush_i) begin
         count_nxt = '0;
      end else if (push && !pop) begin
         count_nxt = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = count_q - CNT_W'(1);
      end
   end

   // Pointers, occupancy and the registered ready flag (low while in reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         count_q <= count_nxt;
         ready_q <= (count_nxt != FULL_CNT);
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
         end
      end
   end

   // Sticky flag: payload changed on a beat that was already stalled last cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q     <= 1'b0;
         prev_data_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         stall_q     <= stall;
         prev_data_q <= in_data_i;
         if (flush_i) begin
            overflow_q <= 1'b0;
         end else if (stall && stall_q && (in_data_i != prev_data_q)) begin
            overflow_q <= 1'b1;
         end
      end
   end

   rv_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push & ~flush_i),
      .waddr (wr_ptr_q),
      .wdata (in_data_i),
      .raddr (rd_ptr_q),
      .rdata (out_data_o)
   );

   assign in_ready_o = ready_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rv_skid_fifo.sv
// Self-checking bench for rv_skid_fifo: directed scenarios followed by a random
// ready/valid run, all compared against a queue-based reference model.
module tb_rv_skid_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_i;
   logic          in_valid_i;
   logic [DW-1:0] in_data_i;
   logic          in_ready_o;
   logic          out_valid_o;
   logic [DW-1:0] out_data_o;
   logic          out_ready_i;
   logic [CW-1:0] count_o;
   logic          overflow_o;

   int    checks   = 0;
   int    failures = 0;
   string phase    = "init";

   // Reference model state: queued payloads plus the sticky-flag bookkeeping.
   logic [DW-1:0] mq [$];
   bit            ready_known;
   bit            ovf_m;
   bit            prev_stall_m;
   logic [DW-1:0] prev_d_m;

   rv_skid_fifo #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .count_o     (count_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time (phase %s)", phase);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
         $error("comparison %s/%s did not hold", phase, tag);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      ready_known  = 1'b0;
      ovf_m        = 1'b0;
      prev_stall_m = 1'b0;
      prev_d_m     = '0;
   endtask

   task automatic check_outputs();
      check("count", 64'(count_o), 64'(mq.size()));
      check("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
      if (ready_known) check("in_ready", 64'(in_ready_o), 64'(mq.size() < DEPTH));
      check("overflow", 64'(overflow_o), 64'(ovf_m));
      if (mq.size() != 0) check("out_data", 64'(out_data_o), 64'(mq[0]));
   endtask

   // One clock: drive inputs, advance the model across the edge, then compare.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, input bit f,
                        output bit acc);
      bit rdy, push, pop, stall;
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = r;
      flush_i     = f;
      rdy   = ready_known && (mq.size() < DEPTH);
      push  = v && rdy;
      pop   = (mq.size() != 0) && r;
      stall = v && !rdy;
      acc   = push;
      @(posedge clk);
      if (f) begin
         mq.delete();
         ovf_m = 1'b0;
      end else begin
         if (stall && prev_stall_m && (d !== prev_d_m)) ovf_m = 1'b1;
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(d);
      end
      prev_stall_m = stall;
      prev_d_m     = d;
      ready_known  = 1'b1;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drain();
      bit a;
      for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
      check("drained", 64'(out_valid_o), 64'(0));
   endtask

   initial begin
      bit            acc;
      bit            pv;
      logic [DW-1:0] pd;
      bit            r;
      bit            f;

      // Reset values while rst_n is held low.
      rst_n       = 1'b0;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      phase = "reset";
      check("count", 64'(count_o), 64'(0));
      check("out_valid", 64'(out_valid_o), 64'(0));
      check("in_ready", 64'(in_ready_o), 64'(0));
      check("overflow", 64'(overflow_o), 64'(0));
      rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0, acc);

      // Streaming through an empty queue: each beat visible one cycle later.
      phase = "stream";
      cycle(1'b1, 8'h11, 1'b1, 1'b0, acc);
      cycle(1'b1, 8'h22, 1'b1, 1'b0, acc);
      cycle(1'b1, 8'h33, 1'b1, 1'b0, acc);
      drain();

      // Fill to DEPTH, hold a fifth beat, free one slot with a single pop.
      phase = "full";
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, acc);
      check("full_ready", 64'(in_ready_o), 64'(0));
      cycle(1'b1, 8'hB4, 1'b0, 1'b0, acc);
      check("fifth_held", 64'(acc), 64'(0));
      cycle(1'b1, 8'hB4, 1'b1, 1'b0, acc);
      check("fifth_held_pop", 64'(acc), 64'(0));
      cycle(1'b1, 8'hB4, 1'b0, 1'b0, acc);
      check("fifth_taken", 64'(acc), 64'(1));
      drain();

      // Steady push+pop at occupancy 2, wrapping both pointers.
      phase = "rw";
      cycle(1'b1, 8'hC0, 1'b0, 1'b0, acc);
      cycle(1'b1, 8'hC1, 1'b0, 1'b0, acc);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC2 + i), 1'b1, 1'b0, acc);
      check("rw_count", 64'(count_o), 64'(2));
      drain();

      // Flush beats a same-edge push.
      phase = "flush";
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, acc);
      cycle(1'b1, 8'hD3, 1'b0, 1'b1, acc);
      check("flush_count", 64'(count_o), 64'(0));
      cycle(1'b0, '0, 1'b1, 1'b0, acc);
      check("flush_empty", 64'(out_valid_o), 64'(0));

      // Payload change while stalled sets the sticky flag until flush.
      phase = "overflow";
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, acc);
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, acc);
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, acc);
      check("ovf_same_data", 64'(overflow_o), 64'(0));
      cycle(1'b1, 8'h5A, 1'b0, 1'b0, acc);
      check("ovf_set", 64'(overflow_o), 64'(1));
      cycle(1'b1, 8'h5A, 1'b1, 1'b0, acc);
      cycle(1'b1, 8'h5A, 1'b0, 1'b0, acc);
      cycle(1'b0, '0, 1'b1, 1'b0, acc);
      check("ovf_sticky", 64'(overflow_o), 64'(1));
      cycle(1'b0, '0, 1'b0, 1'b1, acc);
      check("ovf_cleared", 64'(overflow_o), 64'(0));

      // Asynchronous reset mid-stream, checked before any clock edge.
      phase = "async_rst";
      cycle(1'b1, 8'hF0, 1'b0, 1'b0, acc);
      cycle(1'b1, 8'hF1, 1'b0, 1'b0, acc);
      in_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("count", 64'(count_o), 64'(0));
      check("out_valid", 64'(out_valid_o), 64'(0));
      check("in_ready", 64'(in_ready_o), 64'(0));
      check("overflow", 64'(overflow_o), 64'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
      cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);
      drain();

      // Random traffic obeying the upstream hold rule, with occasional flushes.
      phase = "random";
      pv = 1'b0;
      pd = '0;
      for (int n = 0; n < 400; n++) begin
         if (!pv && ($urandom_range(0, 99) < 60)) begin
            pv = 1'b1;
            pd = DW'($urandom);
         end
         r = ($urandom_range(0, 99) < ((n < 200) ? 30 : 80));
         f = ($urandom_range(0, 99) < 3);
         cycle(pv, pd, r, f, acc);
         if (acc) pv = 1'b0;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
